// File: rtl/seq_shift_unit.sv
// seq_shift_unit: iterative SLL/SRL/SRA/ROL unit shifting STEP bits per clock, valid/ready on both sides.
// Optional registered out_zero result flag enabled by SEQ_SHIFT_ZERO_FLAG_EN.
module seq_shift_unit #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [$clog2(WIDTH)-1:0] in_shamt,
    input  logic [1:0]               in_mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data
`ifdef SEQ_SHIFT_ZERO_FLAG_EN
    ,
    output logic                     out_zero
`endif
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW:0] STEP_W  = (SHW+1)'(STEP);
    localparam logic [SHW:0] WIDTH_W = (SHW+1)'(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SHW-1:0]   rem_q, rem_d;
    logic [1:0]       mode_q;
    logic             sign_q, out_valid_q, zero_q;
    logic [SHW:0]     k;

    // k never exceeds rem, so its low SHW bits are exact even when STEP == WIDTH
    always_comb begin
        k      = ({1'b0, rem_q} < STEP_W) ? {1'b0, rem_q} : STEP_W;
        rem_d  = rem_q - k[SHW-1:0];
        data_d = mode_q == 2'b00 ? data_q << k
               : mode_q == 2'b01 ? data_q >> k
               : mode_q == 2'b10 ? (data_q >> k) | ({WIDTH{sign_q}} & ~({WIDTH{1'b1}} >> k))
               : (data_q << k) | (data_q >> (WIDTH_W - k));
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= IDLE;
            data_q      <= '0;
            rem_q       <= '0;
            mode_q      <= '0;
            sign_q      <= 1'b0;
            out_valid_q <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    data_q      <= in_data;
                    rem_q       <= in_shamt;
                    mode_q      <= in_mode;
                    sign_q      <= in_data[WIDTH-1];
                    state_q     <= in_shamt == '0 ? DONE : SHIFT;
                    out_valid_q <= in_shamt == '0;
                    zero_q      <= in_shamt == '0 && in_data == '0;
                end
                SHIFT: begin
                    data_q <= data_d;
                    rem_q  <= rem_d;
                    if (rem_d == '0) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        zero_q      <= data_d == '0;
                    end
                end
                DONE: if (out_ready) begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    zero_q      <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = Reset_n && state_q == IDLE;
    assign out_valid = out_valid_q;
    assign out_data  = data_q;

`ifdef SEQ_SHIFT_ZERO_FLAG_EN
    assign out_zero = zero_q;
`else
    logic unused_zero;
    assign unused_zero = zero_q;
`endif
endmodule

// File: tb/tb_seq_shift_unit.sv
// tb_seq_shift_unit: directed vector bench for seq_shift_unit at WIDTH=32, STEP=4.
// Checks out_zero as well when SEQ_SHIFT_ZERO_FLAG_EN is defined.
module tb_seq_shift_unit;
    localparam int WIDTH = 32;
    localparam int STEP  = 4;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic [4:0]  in_shamt = '0;
    logic [1:0]  in_mode = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
`ifdef SEQ_SHIFT_ZERO_FLAG_EN
    logic        out_zero;
`endif

    int passed = 0;
    int total  = 0;

    seq_shift_unit #(.WIDTH(WIDTH), .STEP(STEP)) dut (
        .Clk(Clk),
        .Reset_n(Reset_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .in_shamt(in_shamt),
        .in_mode(in_mode),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data)
`ifdef SEQ_SHIFT_ZERO_FLAG_EN
        ,
        .out_zero(out_zero)
`endif
    );

    always #5 Clk = ~Clk;

    typedef struct {
        string       name;
        logic [1:0]  mode;
        logic [4:0]  shamt;
        logic [31:0] data;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // lat counts edges after the accepting edge until out_valid is seen
    task automatic run_op(input vec_t v);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin tick(); n++; end
        check({v.name, " in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = v.data;
        in_shamt = v.shamt;
        in_mode  = v.mode;
        tick();
        in_valid = 1'b0;
        in_data  = $urandom();
        in_shamt = 5'($urandom());
        in_mode  = 2'($urandom());
        n = 0;
        while (!out_valid && n < 100) begin tick(); n++; end
        check({v.name, " latency"}, 32'(n), 32'(v.lat));
        check({v.name, " data"}, out_data, v.exp);
`ifdef SEQ_SHIFT_ZERO_FLAG_EN
        check({v.name, " zero"}, 32'(out_zero), 32'(v.exp == 32'd0));
`endif
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({v.name, " idle"}, {30'd0, in_ready, out_valid}, 32'b10);
    endtask

    vec_t vecs[13];

    initial begin
        vecs[0]  = '{"sll3x2",    2'b00, 5'd2,  32'h0000_0003, 32'h0000_000C, 1};
        vecs[1]  = '{"sra31",     2'b10, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF, 8};
        vecs[2]  = '{"srl31",     2'b01, 5'd31, 32'h8000_0000, 32'h0000_0001, 8};
        vecs[3]  = '{"rol1",      2'b11, 5'd1,  32'h8000_0001, 32'h0000_0003, 1};
        vecs[4]  = '{"sll0",      2'b00, 5'd0,  32'h1234_5678, 32'h1234_5678, 0};
        vecs[5]  = '{"sra0",      2'b10, 5'd0,  32'h8765_4321, 32'h8765_4321, 0};
        vecs[6]  = '{"rol8",      2'b11, 5'd8,  32'h1234_5678, 32'h3456_7812, 2};
        vecs[7]  = '{"sra_pos4",  2'b10, 5'd4,  32'h7FFF_FFF0, 32'h07FF_FFFF, 1};
        vecs[8]  = '{"sra_neg5",  2'b10, 5'd5,  32'hF000_0000, 32'hFF80_0000, 2};
        vecs[9]  = '{"sll31",     2'b00, 5'd31, 32'hFFFF_FFFF, 32'h8000_0000, 8};
        vecs[10] = '{"rol30",     2'b11, 5'd30, 32'h0000_000F, 32'hC000_0003, 8};
        vecs[11] = '{"srl7",      2'b01, 5'd7,  32'hFFFF_FFFF, 32'h01FF_FFFF, 2};
        vecs[12] = '{"srl_zero",  2'b01, 5'd1,  32'h0000_0001, 32'h0000_0000, 1};

        #2 Reset_n = 1'b0;
        #1;
        check("rst in_ready", 32'(in_ready), 32'd0);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst out_data", out_data, 32'd0);
`ifdef SEQ_SHIFT_ZERO_FLAG_EN
        check("rst out_zero", 32'(out_zero), 32'd0);
`endif
        tick();
        tick();
        Reset_n = 1'b1;
        #1;
        check("post rst in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 13; i++) run_op(vecs[i]);
`ifdef SEQ_SHIFT_ZERO_FLAG_EN
        run_op('{"zf_sll31", 2'b00, 5'd31, 32'h0000_0001, 32'h8000_0000, 8});
`endif

        // backpressure: result held, second request ignored
        begin
            int n;
            in_valid = 1'b1; in_data = 32'h0000_0001; in_shamt = 5'd4; in_mode = 2'b00;
            tick();
            in_data = 32'hDEAD_BEEF; in_shamt = 5'd0; in_mode = 2'b11;
            n = 0;
            while (!out_valid && n < 20) begin tick(); n++; end
            check("bp latency", 32'(n), 32'd1);
            for (int i = 0; i < 5; i++) begin
                tick();
                check("bp hold", {in_ready, out_valid, 30'd0} | 32'(out_data), {2'b01, 30'd0} | 32'h10);
            end
            in_valid = 1'b0;
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            check("bp release", {30'd0, in_ready, out_valid}, 32'b10);
            tick();
            check("bp no queued", {30'd0, in_ready, out_valid}, 32'b10);
        end

        // reset in the middle of a shift drops the request
        begin
            vec_t v;
            in_valid = 1'b1; in_data = 32'h0000_0001; in_shamt = 5'd20; in_mode = 2'b00;
            tick();
            in_valid = 1'b0;
            tick(); tick(); tick();
            check("mid busy", {30'd0, in_ready, out_valid}, 32'b00);
            check("mid partial", out_data, 32'h0000_1000);
            #2 Reset_n = 1'b0;
            #1;
            check("async out_valid", 32'(out_valid), 32'd0);
            check("async out_data", out_data, 32'd0);
            check("async in_ready", 32'(in_ready), 32'd0);
            tick();
            Reset_n = 1'b1;
            for (int i = 0; i < 6; i++) tick();
            check("no stale result", {30'd0, in_ready, out_valid}, 32'b10);
            v = '{"after_rst", 2'b00, 5'd1, 32'h0000_0001, 32'h0000_0002, 1};
            run_op(v);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
